sliding_window_generator: RTL and testbench
===========================================

# sliding_window_generator

Streaming window former that sits directly upstream of the pipelined convolution stage. It accepts one pixel per cycle in row-major order, buffers KERNEL_SIZE-1 full rows, and presents a flattened KERNEL_SIZE×KERNEL_SIZE window with a valid strobe. The window bus is bit-compatible with the convolution stage's `data` input. Per image it emits exactly (ROW_SIZE-KERNEL_SIZE+1)*COLUMN_SIZE valid windows, so the convolution stage's column counter stays aligned across back-to-back images.

## Interface
- COLUMN_SIZE, 28: pixels per row
- ROW_SIZE, 28: rows per image
- KERNEL_SIZE, 3: window edge
- DATA_WIDTH, 16: pixel width (fixed-point, passed through untouched)

Ports:
- clock  in  1  rising-edge clock
- sreset_n  in  1  reset, synchronous, active-low
- in_pixel  in  DATA_WIDTH  input pixel
- in_valid  in  1  pixel present
- in_ready  out  1  pixel accepted when in_valid && in_ready
- window  out  DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE  flattened window; element l = r*KERNEL_SIZE+c at bits [DATA_WIDTH*(l+1)-1 : DATA_WIDTH*l]; r=0 oldest row, c=0 leftmost column
- window_valid  out  1  one-cycle strobe per window; drives the convolution stage's `valid`
- frame_done  out  1  one-cycle pulse after the last flush window

## Operation
- Counters: col_cnt 0..COLUMN_SIZE-1 and row_cnt 0..ROW_SIZE-1 advance on each accepted pixel.
- col_cnt wraps at COLUMN_SIZE-1 and increments row_cnt; row_cnt wraps at ROW_SIZE-1.
- Storage: KERNEL_SIZE-1 cascaded row delays of depth COLUMN_SIZE, plus a K×K window register array.
- On acceptance, every window row shifts left by one. The new rightmost column is {row delay K-2 output, …, row delay 0 output, in_pixel}, oldest to newest.
- FSM states:
  - FILL: in_ready=1. Advance to STREAM on accepting the pixel at row_cnt=K-1, col_cnt=K-1.
  - STREAM: in_ready=1. Go to FLUSH on accepting the pixel at row_cnt=ROW_SIZE-1, col_cnt=COLUMN_SIZE-1.
  - FLUSH: in_ready=0. Run K-1 cycles; each cycle shifts a zero column into the window and asserts window_valid. After the last cycle, go to FILL and pulse frame_done.
- window_valid asserts the cycle after each acceptance that enters or occurs in STREAM, and in every FLUSH cycle.
- Windows that wrap across a row boundary are still emitted. The convolution stage suppresses them by column position.
- Row delays are not cleared between images. Stale contents only reach suppressed or pre-STREAM windows.

## Timing
- Latency: window and window_valid are registered. They update 1 cycle after the accepting edge.
- Reset (sreset_n low at an edge): state=FILL, counters=0, window=0, window_valid=0, frame_done=0. in_ready is 1 in the cycle after reset.
- Reset mid-image: the partial image is discarded. The next accepted pixel is treated as (0,0).
- in_valid low in FILL/STREAM: nothing shifts, and window_valid=0 that cycle.
- in_valid high during FLUSH: the pixel is not accepted and must be held by the source.
- Back-to-back images: the first pixel of the next image may be accepted the cycle after FLUSH ends. The maximum FLUSH stall is K-1 cycles per image.
- in_pixel is ignored when not accepted.

## Structure
- Shared package: default DATA_WIDTH, KERNEL_SIZE, COLUMN_SIZE, ROW_SIZE constants, and the window index function l = r*KERNEL_SIZE + c. The convolution stage and the weight loader reuse the same ordering.
- Sub-module `line_buffer`: a single row delay with parameters COLUMN_SIZE and DATA_WIDTH, shift-enable input and output tap. It is instantiated K-1 times.
- FSM, counters and window register array stay in the top.

## Test plan
- Single image, defaults, in_pixel = linear index, in_valid always 1:
  - First window_valid the cycle after pixel 58 is accepted.
  - That window holds l0=0, l4=29, l8=58.
  - 728 window_valid strobes total; frame_done once.
- Flush: after pixel 783 is accepted, in_ready=0 for exactly 2 cycles with window_valid=1 both cycles. Those windows' rightmost columns are 0, then rightmost two columns are 0. in_ready returns to 1 on the next cycle.
- Random in_valid gaps (about 50%):
  - The window sequence matches the gap-free run exactly.
  - window_valid never asserts in a cycle following a non-accepting cycle in FILL/STREAM.
- Two back-to-back images chained into the convolution stage: the convolution stage emits 26×26 = 676 convol_valid per image, with none from wrap windows, across both images.
- Reset asserted after pixel 400:
  - window_valid=0 and in_ready=1 the next cycle.
  - A restarted image gives its first window after its 59th pixel.
- Parameter sweep KERNEL_SIZE=5, COLUMN_SIZE=8, ROW_SIZE=6: first valid after pixel index 36; 16 valids per image; 4 flush cycles.

Source files
------------

// File: rtl/sliding_window_generator_pkg.sv
// Shared constants, FSM encoding and window element ordering
// for the sliding window former and its neighbours.
package sliding_window_generator_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_COLUMN_SIZE = 28;
  localparam int DEF_ROW_SIZE    = 28;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  // Flattened window index: r=0 oldest row, c=0 leftmost column.
  function automatic int win_idx(
    input int r,
    input int c,
    input int k
  );
    return r * k + c;
  endfunction

endpackage

// File: rtl/sliding_window_generator_line_buffer.sv
// One row delay: a COLUMN_SIZE-deep shift register.
// The tap returns the pixel accepted COLUMN_SIZE shifts ago.
module line_buffer
  import sliding_window_generator_pkg::*;
#(
  parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_tap
);

  logic [DATA_WIDTH-1:0] r_mem [COLUMN_SIZE];

  // Shift one slot on every accepted pixel; contents survive reset.
  always_ff @(posedge clock) begin
    if (i_shift) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < COLUMN_SIZE; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_tap = r_mem[COLUMN_SIZE-1];

endmodule

// File: rtl/sliding_window_generator.sv
// Streaming KxK window former: row delays, window registers,
// and a FILL/STREAM/FLUSH controller keeping per-image window count.
module sliding_window_generator
  import sliding_window_generator_pkg::*;
#(
  parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
  parameter int ROW_SIZE    = DEF_ROW_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  sreset_n,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window,
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int FW = (K > 2) ? $clog2(K - 1) : 1;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [FW-1:0] r_flush;

  logic w_accept;
  logic w_shift;
  logic w_row_end;
  logic w_img_end;
  logic w_fill_end;
  logic w_flush_end;
  logic w_enter;

  logic [DATA_WIDTH-1:0] w_lb_in [K-1];
  logic [DATA_WIDTH-1:0] w_tap   [K-1];
  logic [DATA_WIDTH-1:0] w_col   [K];
  logic [DATA_WIDTH-1:0] r_win   [K][K];

  logic r_window_valid;
  logic r_frame_done;

  assign w_accept    = in_valid && in_ready;
  assign w_row_end   = (r_col == CW'(COLUMN_SIZE - 1));
  assign w_img_end   = w_row_end && (r_row == RW'(ROW_SIZE - 1));
  assign w_fill_end  = (r_row == RW'(K - 1)) && (r_col == CW'(K - 1));
  assign w_flush_end = (r_flush == FW'(K - 2));
  assign w_enter     = (r_state == ST_FILL) && w_accept && w_fill_end;
  assign w_shift     = w_accept || (r_state == ST_FLUSH);

  // Cascade of K-1 row delays, newest row first.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign w_lb_in[j] = in_pixel;
    end else begin : g_tail
      assign w_lb_in[j] = w_tap[j-1];
    end
    line_buffer #(
      .COLUMN_SIZE(COLUMN_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lb (
      .clock  (clock),
      .i_shift(w_accept),
      .i_data (w_lb_in[j]),
      .o_tap  (w_tap[j])
    );
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!sreset_n) r_state <= ST_FILL;
    else           r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FILL:   if (w_accept && w_fill_end) w_next = ST_STREAM;
      ST_STREAM: if (w_accept && w_img_end)  w_next = ST_FLUSH;
      ST_FLUSH:  if (w_flush_end)            w_next = ST_FILL;
      default:   w_next = ST_FILL;
    endcase
  end

  // Source is stalled only while flushing.
  always_comb begin
    in_ready = 1'b1;
    unique case (r_state)
      ST_FILL:   in_ready = 1'b1;
      ST_STREAM: in_ready = 1'b1;
      ST_FLUSH:  in_ready = 1'b0;
      default:   in_ready = 1'b0;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_row_end) begin
        r_col <= '0;
        if (r_row == RW'(ROW_SIZE - 1)) r_row <= '0;
        else                            r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Flush cycle counter.
  always_ff @(posedge clock) begin
    if (!sreset_n)                r_flush <= '0;
    else if (r_state != ST_FLUSH) r_flush <= '0;
    else if (w_flush_end)         r_flush <= '0;
    else                          r_flush <= r_flush + 1'b1;
  end

  // Incoming column, oldest row first; zeros while flushing.
  always_comb begin
    for (int r = 0; r < K; r++) w_col[r] = '0;
    if (r_state != ST_FLUSH) begin
      w_col[K-1] = in_pixel;
      for (int r = 0; r < K - 1; r++) w_col[r] = w_tap[K-2-r];
    end
  end

  // Window registers shift left and load the new rightmost column.
  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          r_win[r][c] <= '0;
    end else if (w_shift) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-1] <= w_col[r];
      end
    end
  end

  // Window strobe and end-of-image pulse.
  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_window_valid <= (r_state == ST_FLUSH) ||
                        (w_accept && (r_state == ST_STREAM)) ||
                        w_enter;
      r_frame_done   <= (r_state == ST_FLUSH) && w_flush_end;
    end
  end

  // Flatten window registers onto the convolution data bus.
  always_comb begin
    window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        window[DATA_WIDTH*win_idx(r, c, K) +: DATA_WIDTH] = r_win[r][c];
  end

  assign window_valid = r_window_valid;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_sliding_window_generator.sv
// Bench for sliding_window_generator: random images against a
// linear-index window model, plus a small-parameter instance.
module tb_sliding_window_generator;

  localparam int K  = 3;
  localparam int C  = 28;
  localparam int R  = 28;
  localparam int DW = 16;
  localparam int WW = DW * K * K;
  localparam int N  = R * C;

  localparam int SK  = 5;
  localparam int SC  = 8;
  localparam int SR  = 6;
  localparam int SWW = DW * SK * SK;
  localparam int SN  = SR * SC;

  logic          clock;
  logic          sreset_n;
  logic [DW-1:0] in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] window;
  logic          window_valid;
  logic          frame_done;

  logic           s_in_valid;
  logic [DW-1:0]  s_in_pixel;
  logic           s_in_ready;
  logic [SWW-1:0] s_window;
  logic           s_window_valid;
  logic           s_frame_done;

  sliding_window_generator #(
    .COLUMN_SIZE(C), .ROW_SIZE(R),
    .KERNEL_SIZE(K), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock), .sreset_n(sreset_n),
    .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .window(window),
    .window_valid(window_valid), .frame_done(frame_done)
  );

  sliding_window_generator #(
    .COLUMN_SIZE(SC), .ROW_SIZE(SR),
    .KERNEL_SIZE(SK), .DATA_WIDTH(DW)
  ) dut_s (
    .clock(clock), .sreset_n(sreset_n),
    .in_pixel(s_in_pixel), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .window(s_window),
    .window_valid(s_window_valid), .frame_done(s_frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] img [N];
  logic [WW-1:0] q_win [$];
  int first_acc;
  int n_fd;
  int n_ready_lo;
  int n_lo_valid;
  int n_viol;
  bit timed_out;
  int conv_col;

  // Strobe n has its newest pixel at stream position p; each window
  // column c comes from position q, row r lies (K-1-r) rows above it.
  // Positions past the image are the zero flush columns.
  function automatic logic [WW-1:0] exp_win(input int n);
    logic [WW-1:0] w;
    int p;
    int q;
    w = '0;
    p = n + (K - 1) * C + (K - 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        q = p - (K - 1 - c);
        if (q < N) w[DW*(r*K+c) +: DW] = img[q - (K - 1 - r) * C];
      end
    return w;
  endfunction

  // True (non-wrapping) window m of an image, in output raster order.
  function automatic logic [WW-1:0] exp_conv(input int m);
    logic [WW-1:0] w;
    int orow;
    int ocol;
    orow = m / (C - K + 1);
    ocol = m % (C - K + 1);
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[DW*(r*K+c) +: DW] = img[(orow + r) * C + ocol + c];
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) img[i] = DW'($urandom);
  endtask

  // Stream img[0..lim-1]; a full image runs until frame_done.
  task automatic drive_image(input int gap_pct, input int lim);
    int acc;
    int cyc;
    bit idle_prev;
    bit acc_now;
    bit done;
    acc = 0;
    cyc = 0;
    done = 0;
    q_win.delete();
    first_acc = -1;
    n_fd = 0;
    n_ready_lo = 0;
    n_lo_valid = 0;
    n_viol = 0;
    timed_out = 0;
    while (!done) begin
      if (acc < lim && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_pixel = img[acc];
      end else begin
        in_valid = 1'b0;
        in_pixel = DW'($urandom);
      end
      idle_prev = in_ready && !in_valid;
      acc_now = in_ready && in_valid;
      @(posedge clock);
      #1;
      if (acc_now) acc++;
      if (window_valid) begin
        q_win.push_back(window);
        if (first_acc < 0) first_acc = acc;
        if (idle_prev) n_viol++;
      end
      if (!in_ready) n_ready_lo++;
      if (!in_ready && window_valid) n_lo_valid++;
      if (frame_done) n_fd++;
      cyc++;
      if (lim < N) done = (acc == lim);
      else         done = frame_done;
      if (cyc > 6000) begin
        timed_out = 1;
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    sreset_n = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    s_in_valid = 1'b0;
    s_in_pixel = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_window_valid: got %b expected 0", window_valid);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b expected 0", frame_done);
    end
    checks++;
    if (window !== '0) begin
      errors++;
      $display("FAIL reset_window: got %h expected 0", window);
    end
    checks++;
    if (s_in_ready !== 1'b1 || s_window_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_sweep: got ready=%b valid=%b expected 1 0",
               s_in_ready, s_window_valid);
    end
    sreset_n = 1'b1;
  endtask

  task automatic test_single_image();
    int mism;
    logic [WW-1:0] w;
    for (int i = 0; i < N; i++) img[i] = DW'(i);
    drive_image(0, N);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++;
      $display("FAIL single_timeout: got %b expected 0", timed_out);
    end
    checks++;
    if (first_acc !== 59) begin
      errors++;
      $display("FAIL single_first_valid: got after %0d pixels expected 59", first_acc);
    end
    checks++;
    if (q_win.size() !== 728) begin
      errors++;
      $display("FAIL single_count: got %0d expected 728", q_win.size());
    end
    if (q_win.size() > 0) begin
      w = q_win[0];
      checks++;
      if (w[0 +: DW] !== 16'd0 || w[4*DW +: DW] !== 16'd29 ||
          w[8*DW +: DW] !== 16'd58) begin
        errors++;
        $display("FAIL single_first_win: got l0=%0d l4=%0d l8=%0d expected 0 29 58",
                 w[0 +: DW], w[4*DW +: DW], w[8*DW +: DW]);
      end
    end
    if (q_win.size() >= 2) begin
      w = q_win[q_win.size()-2];
      checks++;
      if (w[2*DW +: DW] !== '0 || w[5*DW +: DW] !== '0 ||
          w[8*DW +: DW] !== '0 || w[7*DW +: DW] !== 16'd783) begin
        errors++;
        $display("FAIL flush1_col: got %h expected right column 0 and l7=783", w);
      end
      w = q_win[q_win.size()-1];
      checks++;
      if (w[1*DW +: DW] !== '0 || w[4*DW +: DW] !== '0 ||
          w[7*DW +: DW] !== '0 || w[6*DW +: DW] !== 16'd783) begin
        errors++;
        $display("FAIL flush2_col: got %h expected two right columns 0 and l6=783", w);
      end
    end
    checks++;
    if (n_ready_lo !== 2 || n_lo_valid !== 2) begin
      errors++;
      $display("FAIL flush_stall: got %0d stall cycles %0d with valid expected 2 2",
               n_ready_lo, n_lo_valid);
    end
    checks++;
    if (n_fd !== 1) begin
      errors++;
      $display("FAIL single_frame_done: got %0d expected 1", n_fd);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_release: got in_ready=%b expected 1", in_ready);
    end
    mism = 0;
    for (int i = 0; i < q_win.size(); i++)
      if (q_win[i] !== exp_win(i)) mism++;
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL single_windows: got %0d wrong windows expected 0", mism);
    end
  endtask

  task automatic test_gaps();
    int mism;
    fill_random();
    drive_image(50, N);
    checks++;
    if (timed_out !== 1'b0 || q_win.size() !== 728) begin
      errors++;
      $display("FAIL gaps_count: got %0d windows timeout=%b expected 728 0",
               q_win.size(), timed_out);
    end
    mism = 0;
    for (int i = 0; i < q_win.size(); i++)
      if (q_win[i] !== exp_win(i)) mism++;
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL gaps_windows: got %0d wrong windows expected 0", mism);
    end
    checks++;
    if (n_viol !== 0) begin
      errors++;
      $display("FAIL gaps_idle_valid: got %0d strobes after idle cycles expected 0", n_viol);
    end
    checks++;
    if (n_fd !== 1) begin
      errors++;
      $display("FAIL gaps_frame_done: got %0d expected 1", n_fd);
    end
  endtask

  task automatic test_back_to_back();
    int nconv;
    int mism;
    conv_col = K - 1;
    for (int im = 0; im < 2; im++) begin
      fill_random();
      drive_image(0, N);
      nconv = 0;
      mism = 0;
      for (int i = 0; i < q_win.size(); i++) begin
        if (conv_col >= K - 1) begin
          if (q_win[i] !== exp_conv(nconv)) mism++;
          nconv++;
        end
        conv_col = (conv_col + 1) % C;
      end
      checks++;
      if (nconv !== 676 || timed_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_conv_count[%0d]: got %0d expected 676", im, nconv);
      end
      checks++;
      if (mism !== 0) begin
        errors++;
        $display("FAIL b2b_conv_windows[%0d]: got %0d wrong windows expected 0", im, mism);
      end
      checks++;
      if (first_acc !== 59 || n_fd !== 1) begin
        errors++;
        $display("FAIL b2b_framing[%0d]: got first=%0d done=%0d expected 59 1",
                 im, first_acc, n_fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int mism;
    fill_random();
    drive_image(0, 401);
    sreset_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    sreset_n = 1'b1;
    checks++;
    if (window_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b ready=%b expected 0 1",
               window_valid, in_ready);
    end
    fill_random();
    drive_image(30, N);
    checks++;
    if (first_acc !== 59) begin
      errors++;
      $display("FAIL restart_first_valid: got after %0d pixels expected 59", first_acc);
    end
    mism = 0;
    for (int i = 0; i < q_win.size(); i++)
      if (q_win[i] !== exp_win(i)) mism++;
    checks++;
    if (mism !== 0 || q_win.size() !== 728) begin
      errors++;
      $display("FAIL restart_windows: got %0d wrong of %0d expected 0 of 728",
               mism, q_win.size());
    end
  endtask

  task automatic test_param_sweep();
    int acc;
    int cyc;
    int first;
    int nv;
    int lo;
    int fd;
    bit ok;
    bit done;
    logic [SWW-1:0] w0;
    acc = 0;
    cyc = 0;
    first = -1;
    nv = 0;
    lo = 0;
    fd = 0;
    done = 0;
    w0 = '0;
    while (!done) begin
      s_in_valid = (acc < SN);
      s_in_pixel = (acc < SN) ? DW'(acc) : DW'($urandom);
      ok = s_in_valid && s_in_ready;
      @(posedge clock);
      #1;
      if (ok) acc++;
      if (s_window_valid) begin
        if (first < 0) begin
          first = acc - 1;
          w0 = s_window;
        end
        nv++;
      end
      if (!s_in_ready) lo++;
      if (s_frame_done) begin
        fd++;
        done = 1;
      end
      cyc++;
      if (cyc > 500) done = 1;
    end
    s_in_valid = 1'b0;
    checks++;
    if (first !== 36) begin
      errors++;
      $display("FAIL sweep_first_valid: got pixel %0d expected 36", first);
    end
    checks++;
    if (nv !== 16) begin
      errors++;
      $display("FAIL sweep_count: got %0d expected 16", nv);
    end
    checks++;
    if (lo !== 4) begin
      errors++;
      $display("FAIL sweep_flush_cycles: got %0d expected 4", lo);
    end
    checks++;
    if (fd !== 1) begin
      errors++;
      $display("FAIL sweep_frame_done: got %0d expected 1", fd);
    end
    checks++;
    if (w0[0 +: DW] !== 16'd0 || w0[12*DW +: DW] !== 16'd18 ||
        w0[24*DW +: DW] !== 16'd36) begin
      errors++;
      $display("FAIL sweep_first_win: got l0=%0d l12=%0d l24=%0d expected 0 18 36",
               w0[0 +: DW], w0[12*DW +: DW], w0[24*DW +: DW]);
    end
  endtask

  initial begin
    test_reset();
    test_single_image();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
